// File: rtl/sl_pkg.sv
// Shared definitions for the SL serial-line transmitter/receiver pair:
// config word layout, frame sizing and the transmitter state encoding.
package sl_pkg;

  localparam int unsigned SL_LEN_LSB  = 0;
  localparam int unsigned SL_LEN_W    = 6;
  localparam int unsigned SL_PAR_EN   = 6;
  localparam int unsigned SL_PAR_ODD  = 7;
  localparam int unsigned SL_HALF_LSB = 8;
  localparam int unsigned SL_HALF_W   = 16;
  localparam int unsigned SL_MAX_LEN  = 32;
  localparam int unsigned SL_FRAME_W  = SL_MAX_LEN + 1;
  localparam int unsigned SL_STATE_W  = 3;

  typedef logic [SL_STATE_W-1:0] sl_tx_state_t;

  localparam sl_tx_state_t IDLE     = 3'd0;
  localparam sl_tx_state_t PULSE    = 3'd1;
  localparam sl_tx_state_t GAP      = 3'd2;
  localparam sl_tx_state_t STOP     = 3'd3;
  localparam sl_tx_state_t STOP_GAP = 3'd4;

  // Out-of-range lengths (0 or above the maximum) fall back to a full word.
  function automatic logic [SL_LEN_W-1:0] sl_decode_len(input logic [SL_LEN_W-1:0] raw);
    if (raw == '0 || raw > SL_LEN_W'(SL_MAX_LEN)) return SL_LEN_W'(SL_MAX_LEN);
    return raw;
  endfunction

  function automatic logic [SL_HALF_W-1:0] sl_decode_half(input logic [SL_HALF_W-1:0] raw,
                                                         input logic [SL_HALF_W-1:0] dflt);
    return (raw == '0) ? dflt : raw;
  endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// Loadable down-counter; expire_c marks the last cycle of a loaded interval.
module sl_bit_timer
  import sl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [SL_HALF_W-1:0] load_val,
  output logic                 expire_c
);

  logic [SL_HALF_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - SL_HALF_W'(1);
  end

  assign expire_c = (cnt == SL_HALF_W'(1));

endmodule

// File: rtl/sl_transmitter.sv
// SL transmitter: serialises a latched word as timed low pulses on sl0/sl1,
// optional parity bit, then a both-low stop marker.
module sl_transmitter
  import sl_pkg::*;
#(
  parameter logic [SL_HALF_W-1:0] DEFAULT_HALF = 16'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [31:0] config_in,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        sl0,
  output logic        sl1
);

  sl_tx_state_t          state_q, state_nx;
  logic [SL_FRAME_W-1:0] frame_q, frame_nx;
  logic [SL_LEN_W-1:0]   bits_q, bits_nx;
  logic [SL_HALF_W-1:0]  half_q, half_nx;
  logic                  sl0_nx, sl1_nx, done_nx;
  logic                  load_c, expire_c;
  logic [SL_HALF_W-1:0]  load_val_c;

  logic [SL_LEN_W-1:0]   len_c, bits_c;
  logic [SL_HALF_W-1:0]  half_c;
  logic [SL_FRAME_W-1:0] mask_c, data_m_c, frame_c;
  logic                  par_c;
  logic                  rsvd_unused;

  // Decode the request; bits above word_len never reach the frame.
  assign len_c    = sl_decode_len(config_in[SL_LEN_LSB +: SL_LEN_W]);
  assign half_c   = sl_decode_half(config_in[SL_HALF_LSB +: SL_HALF_W], DEFAULT_HALF);
  assign mask_c   = (SL_FRAME_W'(1) << len_c) - SL_FRAME_W'(1);
  assign data_m_c = {1'b0, data_in} & mask_c;
  assign par_c    = (^data_m_c) ^ config_in[SL_PAR_ODD];
  assign frame_c  = data_m_c |
                    (config_in[SL_PAR_EN] ? (SL_FRAME_W'(par_c) << len_c) : '0);
  assign bits_c   = len_c + SL_LEN_W'(config_in[SL_PAR_EN]);
  assign rsvd_unused = ^config_in[31:24];

  sl_bit_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load_c),
    .load_val (load_val_c),
    .expire_c (expire_c)
  );

  // Next-state and next-output decode; every phase change reloads the timer.
  always_comb begin
    state_nx   = state_q;
    frame_nx   = frame_q;
    bits_nx    = bits_q;
    half_nx    = half_q;
    sl0_nx     = sl0;
    sl1_nx     = sl1;
    done_nx    = 1'b0;
    load_c     = 1'b0;
    load_val_c = half_q;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_nx   = PULSE;
          frame_nx   = frame_c;
          bits_nx    = bits_c;
          half_nx    = half_c;
          load_c     = 1'b1;
          load_val_c = half_c;
          sl0_nx     = frame_c[0];
          sl1_nx     = ~frame_c[0];
        end
      end
      PULSE: begin
        if (expire_c) begin
          state_nx = GAP;
          frame_nx = {1'b0, frame_q[SL_FRAME_W-1:1]};
          bits_nx  = bits_q - SL_LEN_W'(1);
          load_c   = 1'b1;
          sl0_nx   = 1'b1;
          sl1_nx   = 1'b1;
        end
      end
      GAP: begin
        if (expire_c) begin
          load_c = 1'b1;
          if (bits_q == '0) begin
            state_nx = STOP;
            sl0_nx   = 1'b0;
            sl1_nx   = 1'b0;
          end else begin
            state_nx = PULSE;
            sl0_nx   = frame_q[0];
            sl1_nx   = ~frame_q[0];
          end
        end
      end
      STOP: begin
        if (expire_c) begin
          state_nx = STOP_GAP;
          load_c   = 1'b1;
          sl0_nx   = 1'b1;
          sl1_nx   = 1'b1;
        end
      end
      STOP_GAP: begin
        if (expire_c) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        sl0_nx   = 1'b1;
        sl1_nx   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      bits_q   <= '0;
      half_q   <= '0;
      sl0      <= 1'b1;
      sl1      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      state_q  <= state_nx;
      frame_q  <= frame_nx;
      bits_q   <= bits_nx;
      half_q   <= half_nx;
      sl0      <= sl0_nx;
      sl1      <= sl1_nx;
      busy     <= (state_nx != IDLE);
      done     <= done_nx;
      tx_ready <= (state_nx == IDLE);
    end
  end

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: decodes the line back into bits and
// checks timing, parity, handshake and reset behaviour.
module tb_sl_transmitter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic [31:0] config_in = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, busy, done, sl0, sl1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] rx_word;
  int rx_n, busy_n, done_at, wmin, wmax, gmin, gmax, stop_len, stop_runs, ready_hi;

  always #5 clock = ~clock;

  sl_transmitter #(.DEFAULT_HALF(16'd4)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .config_in (config_in),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .sl0       (sl0),
    .sl1       (sl1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start(input logic [31:0] d, input logic [31:0] c);
    @(negedge clock);
    data_in   = d;
    config_in = c;
    tx_valid  = 1'b1;
  endtask

  // Watch one frame from the cycle after accept until done (bounded).
  task automatic watch(input int max_c, input bit hold, input int chg_at,
                       input logic [31:0] chg_d);
    logic [1:0] sym, prev;
    int run;
    rx_word = '0; rx_n = 0; busy_n = 0; done_at = 0; stop_len = 0; stop_runs = 0;
    ready_hi = 0; wmin = 1 << 30; wmax = 0; gmin = 1 << 30; gmax = 0;
    prev = 2'b11; run = 0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clock);
      sym = {sl0, sl1};
      if (busy) busy_n++;
      if (busy && tx_ready) ready_hi++;
      if (sym != prev) begin
        if (prev == 2'b01 || prev == 2'b10) begin
          rx_word = rx_word | (64'(prev == 2'b10) << rx_n);
          rx_n++;
          if (run < wmin) wmin = run;
          if (run > wmax) wmax = run;
        end else if (prev == 2'b00) begin
          stop_runs++;
          stop_len = run;
        end else if (run > 0) begin
          if (run < gmin) gmin = run;
          if (run > gmax) gmax = run;
        end
        prev = sym;
        run  = 1;
      end else begin
        run++;
      end
      if (c == 1 && !hold) tx_valid = 1'b0;
      if (c == chg_at) data_in = chg_d;
      if (done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [63:0] exp_word,
                             input int exp_n, input int exp_busy, input int half);
    chk({name, "_bits"},      rx_word,          exp_word);
    chk({name, "_nbits"},     64'(rx_n),        64'(exp_n));
    chk({name, "_busy"},      64'(busy_n),      64'(exp_busy));
    chk({name, "_done_at"},   64'(done_at),     64'(exp_busy + 1));
    chk({name, "_pulse_min"}, 64'(wmin),        64'(half));
    chk({name, "_pulse_max"}, 64'(wmax),        64'(half));
    chk({name, "_gap_min"},   64'(gmin),        64'(half));
    chk({name, "_gap_max"},   64'(gmax),        64'(half));
    chk({name, "_stop_runs"}, 64'(stop_runs),   64'(1));
    chk({name, "_stop_len"},  64'(stop_len),    64'(half));
    chk({name, "_ready_lo"},  64'(ready_hi),    64'(0));
  endtask

  initial begin
    int dn;
    repeat (2) @(negedge clock);
    chk("rst_sl0",   64'(sl0),      64'(1));
    chk("rst_sl1",   64'(sl1),      64'(1));
    chk("rst_ready", 64'(tx_ready), 64'(1));
    chk("rst_busy",  64'(busy),     64'(0));
    chk("rst_done",  64'(done),     64'(0));
    reset = 1'b0;

    start(32'h0000_00A5, 32'h0000_0408);
    watch(90, 1'b0, 0, '0);
    check_frame("a5", 64'hA5, 8, 72, 4);
    @(negedge clock);
    chk("a5_done_once", 64'(done),     64'(0));
    chk("a5_idle_ready", 64'(tx_ready), 64'(1));

    start(32'h0000_0007, 32'h0000_0448);
    watch(100, 1'b0, 0, '0);
    check_frame("par_even", 64'h107, 9, 80, 4);

    start(32'h0000_0007, 32'h0000_04C8);
    watch(100, 1'b0, 0, '0);
    check_frame("par_odd", 64'h007, 9, 80, 4);

    start(32'hFFFF_FFFF, 32'h0000_0000);
    watch(300, 1'b0, 0, '0);
    check_frame("len32_dflt", 64'hFFFF_FFFF, 32, 264, 4);

    start(32'h1234_5678, 32'h0000_0228);
    watch(160, 1'b0, 0, '0);
    check_frame("len40", 64'h1234_5678, 32, 132, 2);

    start(32'h0000_0001, 32'h0000_0101);
    watch(20, 1'b0, 0, '0);
    check_frame("len1", 64'h1, 1, 4, 1);

    // Valid held high; data swapped mid-frame becomes the second word.
    start(32'h0000_00C3, 32'h0000_0408);
    watch(90, 1'b1, 10, 32'h0000_003C);
    check_frame("b2b_a", 64'hC3, 8, 72, 4);
    chk("b2b_ready_on_done", 64'(tx_ready), 64'(1));
    watch(90, 1'b0, 0, '0);
    check_frame("b2b_b", 64'h3C, 8, 72, 4);

    // Abort mid-frame while sl1 is low.
    start(32'h0000_00FF, 32'h0000_0408);
    watch(10, 1'b0, 0, '0);
    chk("abort_pre_sl1", 64'(sl1), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    chk("abort_sl0",   64'(sl0),      64'(1));
    chk("abort_sl1",   64'(sl1),      64'(1));
    chk("abort_busy",  64'(busy),     64'(0));
    chk("abort_ready", 64'(tx_ready), 64'(1));
    chk("abort_done",  64'(done),     64'(0));
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'(0));

    start(32'h0000_00A5, 32'h0000_0408);
    watch(90, 1'b0, 0, '0);
    check_frame("post_rst", 64'hA5, 8, 72, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sl_transmitter.md
Name: sl_transmitter

Overview:
Serial-line (SL) transmitter sitting directly downstream of the APB register block. It accepts a 32-bit data word and a 32-bit config word (the APB block's data/config register outputs), then serialises the word onto a two-wire SL line (sl0/sl1) with optional parity and an end-of-word marker. Each bit is a timed low pulse on one wire. Completion is reported back as a one-cycle done strobe and a busy flag for the APB status path.

Parameters:
DEFAULT_HALF, 16'd4, half-bit period in clocks used when config half-period field is 0 (must be >=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
data_in  input  32  word to transmit, LSB first
config_in  input  32  [5:0] word_len, [6] parity_en, [7] parity_odd, [23:8] half_period, [31:24] reserved (ignored)
tx_valid  input  1  request to send data_in with config_in
tx_ready  output  1  block can accept a word this cycle
busy  output  1  frame in progress
done  output  1  one-cycle strobe after frame end
sl0  output  1  line 0, idle high; low pulse = bit 0
sl1  output  1  line 1, idle high; low pulse = bit 1

Behaviour:
- One clock, reset is synchronous and active-high; clock port named clock, reset port named reset.
- Reset values: sl0=1, sl1=1, tx_ready=1, busy=0, done=0, state IDLE, counters 0. Reset mid-frame aborts; lines high on the first edge with reset sampled high.
- Handshake: accept when tx_valid && tx_ready at a rising edge; data_in/config_in latched that edge; later input changes ignored. tx_ready=1 only in IDLE; no buffering.
- Config decode at accept: word_len 0 or >32 -> 32; half_period 0 -> DEFAULT_HALF. Bits above word_len in data_in ignored.
- Parity bit (parity_en=1): even mode -> count of ones in data bits + parity bit is even; parity_odd=1 -> odd.
- States: IDLE -> PULSE (drive bit) -> GAP (both high) -> PULSE for next bit ... -> STOP (sl0 and sl1 both low) -> STOP_GAP (both high) -> IDLE.
- Each PULSE/GAP/STOP/STOP_GAP lasts exactly half_period clocks. Outputs registered: first pulse low in the cycle after the accept edge.
- Bit order: data bit 0 first, up to bit word_len-1, then parity (if enabled), then STOP.
- Frame length F = (word_len + parity_en + 1) * 2 * half_period clocks. busy=1 for exactly F cycles starting the cycle after accept.
- done=1 for one cycle, the cycle after the last STOP_GAP cycle. tx_ready=1 in that same cycle, so back-to-back accept is possible. Gap between frames is therefore >= half_period + 1.
- sl0 and sl1 are never both low outside STOP.
- Bit counter: 6 bits. Half-period counter: 16 bits, counts down to 1, reloads; no wrap issues since reload is >=1.

Decomposition:
- Package sl_pkg: config field offsets/widths (SL_LEN_LSB=0, SL_PAR_EN=6, SL_PAR_ODD=7, SL_HALF_LSB=8), SL_MAX_LEN=32, state enum sl_tx_state_t {IDLE, PULSE, GAP, STOP, STOP_GAP}.
- Sub-module sl_bit_timer: loadable 16-bit down-counter with load value and one-cycle expire pulse. Shared with the future SL receiver.

Test Plan:
- half=4, len=8, no parity, data=0xA5 -> pulses sl1,sl0,sl1,sl0,sl0,sl1,sl0,sl1, each 4 low + 4 high; then both low 4, high 4; busy 72 cycles; done at cycle 73 after accept.
- len=8, parity even, data=0x07 -> ninth pulse on sl1 (parity 1); repeat with parity_odd=1 -> ninth pulse on sl0; frame = 80 cycles at half=4.
- config_in=0 (len->32, half->DEFAULT_HALF=4), data=0xFFFFFFFF -> 32 sl1 pulses then STOP; busy 264 cycles; sl0 low only during STOP.
- tx_valid held high with two words queued by testbench -> second accepted exactly on the done cycle; tx_ready low throughout frame 1; data change mid-frame has no effect.
- reset asserted at cycle 10 of a frame (sl1 low) -> next edge: sl0=sl1=1, busy=0, tx_ready=1, no done; new frame after reset runs correctly.
- word_len=40 -> treated as 32; word_len=1, half=1, data=1 -> sl1 low 1, high 1, both low 1, high 1, done on cycle 5.
